// File: rtl/early_dbc_multi.sv
// early_dbc_multi: N-channel early-detection switch debouncer.
// A shared prescaler produces a periodic tick.
// Each channel's 4-state FSM reports a press on the first active edge.
// It then ignores its input for a lockout of WAIT_TICKS ticks.
// Outputs: debounced level plus one-cycle rise/fall event pulses.
// Optional input synchronizer: define EARLY_DBC_SYNC_EN to add a 2-flop
// synchronizer per btn bit (adds 2 cycles of input latency).
module early_dbc_multi #(
  parameter int N          = 4,
  parameter int TICK_M     = 1_000_000,
  parameter int WAIT_TICKS = 3,
  parameter int EARLY      = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] btn,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         tick
);

  localparam int PW = (TICK_M > 1) ? $clog2(TICK_M) : 1;
  localparam int CW = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_M - 1);
  localparam logic [CW-1:0] C_LAST = CW'(WAIT_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  logic [PW-1:0] pcount;
  logic          tick_raw;
  logic [N-1:0]  b;

  state_t        state_reg  [N];
  state_t        state_next [N];
  logic [CW-1:0] cnt_reg    [N];
  logic [CW-1:0] cnt_next   [N];

  assign tick_raw = (pcount == P_LAST);
  assign tick     = reset_n & tick_raw;

  // Shared prescaler: counts 0..TICK_M-1 and wraps
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcount <= '0;
    end else if (tick_raw) begin
      pcount <= '0;
    end else begin
      pcount <= pcount + PW'(1);
    end
  end

`ifdef EARLY_DBC_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  // Two-flop synchronizer for asynchronous switch inputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign b = sync2;
`else
  assign b = btn;
`endif

  // Per-channel state and lockout counter registers
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (!reset_n) begin
        state_reg[i] <= ZERO;
        cnt_reg[i]   <= '0;
      end else begin
        state_reg[i] <= state_next[i];
        cnt_reg[i]   <= cnt_next[i];
      end
    end
  end

  // Per-channel next-state: lockout decision uses b only at the final tick
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      state_next[i] = state_reg[i];
      cnt_next[i]   = cnt_reg[i];
      case (state_reg[i])
        ZERO: begin
          if (b[i]) begin
            state_next[i] = WAIT1;
            cnt_next[i]   = '0;
          end
        end
        WAIT1, WAIT0: begin
          if (tick_raw) begin
            if (cnt_reg[i] == C_LAST) begin
              state_next[i] = b[i] ? ONE : ZERO;
            end else begin
              cnt_next[i] = cnt_reg[i] + CW'(1);
            end
          end
        end
        ONE: begin
          if (!b[i]) begin
            state_next[i] = WAIT0;
            cnt_next[i]   = '0;
          end
        end
        default: state_next[i] = ZERO;
      endcase
    end
  end

  // Level and event outputs, all forced low while reset is asserted
  always_comb begin
    db   = '0;
    rise = '0;
    fall = '0;
    if (reset_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        case (state_reg[i])
          WAIT1, ONE: db[i] = 1'b1;
          WAIT0:      db[i] = 1'b0;
          default:    db[i] = (EARLY != 0) && b[i];
        endcase
        rise[i] = !(state_reg[i] inside {WAIT1, ONE}) &&  (state_next[i] inside {WAIT1, ONE});
        fall[i] =  (state_reg[i] inside {WAIT1, ONE}) && !(state_next[i] inside {WAIT1, ONE});
      end
    end
  end

endmodule

// File: tb/tb_early_dbc_multi.sv
// Testbench for early_dbc_multi.
// Two instances share stimulus: one uses the early output, one the delayed output.
// The reference model tracks each channel as a committed level and a lockout countdown.
module tb_early_dbc_multi;

  localparam int N          = 2;
  localparam int TICK_M     = 4;
  localparam int WAIT_TICKS = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn;
  logic [N-1:0] db_e, rise_e, fall_e;
  logic [N-1:0] db_m, rise_m, fall_m;
  logic         tick_e, tick_m;

  always #5 clk = ~clk;

  early_dbc_multi #(.N(N), .TICK_M(TICK_M), .WAIT_TICKS(WAIT_TICKS), .EARLY(1)) dut_e (
    .clk(clk), .reset_n(reset_n), .btn(btn),
    .db(db_e), .rise(rise_e), .fall(fall_e), .tick(tick_e)
  );

  early_dbc_multi #(.N(N), .TICK_M(TICK_M), .WAIT_TICKS(WAIT_TICKS), .EARLY(0)) dut_m (
    .clk(clk), .reset_n(reset_n), .btn(btn),
    .db(db_m), .rise(rise_m), .fall(fall_m), .tick(tick_m)
  );

  // Reference model state
  bit         m_level  [N];
  bit         m_locked [N];
  int         m_left   [N];
  int         cyc = 0;
  logic [N-1:0] s1 = '0, s2 = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int rise_cnt = 0;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  task automatic step(input logic rn, input logic [N-1:0] b_in);
    logic [N-1:0] beff, e_db1, e_db0, e_rise, e_fall;
    logic         e_tick;
    bit           nl [N];
    bit           nk [N];
    int           nleft [N];
    @(negedge clk);
    reset_n = rn;
    btn     = b_in;
    #1;
`ifdef EARLY_DBC_SYNC_EN
    beff = s2;
`else
    beff = b_in;
`endif
    e_tick = rn && ((cyc % TICK_M) == TICK_M - 1);
    for (int ch = 0; ch < N; ch++) begin
      nl[ch]    = m_level[ch];
      nk[ch]    = m_locked[ch];
      nleft[ch] = m_left[ch];
      if (!rn) begin
        nl[ch] = 0; nk[ch] = 0; nleft[ch] = 0;
      end else if (!m_locked[ch]) begin
        if (beff[ch] != m_level[ch]) begin
          nl[ch] = beff[ch]; nk[ch] = 1; nleft[ch] = WAIT_TICKS;
        end
      end else if (e_tick) begin
        nleft[ch] = m_left[ch] - 1;
        if (nleft[ch] == 0) begin
          nk[ch] = 0; nl[ch] = beff[ch];
        end
      end
      e_db0[ch]  = rn && m_level[ch];
      e_db1[ch]  = rn && (m_level[ch] || (!m_locked[ch] && beff[ch]));
      e_rise[ch] = rn && nl[ch] && !m_level[ch];
      e_fall[ch] = rn && !nl[ch] && m_level[ch];
    end
    check("db_early",  db_e,   e_db1);
    check("db_moore",  db_m,   e_db0);
    check("rise",      rise_e, e_rise);
    check("fall",      fall_e, e_fall);
    check("rise_m",    rise_m, e_rise);
    check("fall_m",    fall_m, e_fall);
    check("tick",      {1'b0, tick_e}, {1'b0, e_tick});
    rise_cnt += int'(rise_e[0]);
    for (int ch = 0; ch < N; ch++) begin
      m_level[ch]  = nl[ch];
      m_locked[ch] = nk[ch];
      m_left[ch]   = nleft[ch];
    end
    cyc = rn ? cyc + 1 : 0;
    s2  = rn ? s1 : '0;
    s1  = rn ? b_in : '0;
  endtask

  task automatic hold(input logic rn, input logic [N-1:0] b_in, input int n);
    for (int k = 0; k < n; k++) step(rn, b_in);
  endtask

  initial begin
    logic [N-1:0] cur;
    logic         rn;
    reset_n = 1'b0;
    btn     = '0;
    for (int ch = 0; ch < N; ch++) begin
      m_level[ch] = 0; m_locked[ch] = 0; m_left[ch] = 0;
    end

    // Reset with buttons held, then release: both channels press at once
    hold(1'b0, 2'b11, 3);
    hold(1'b1, 2'b11, 16);
    hold(1'b1, 2'b00, 16);

    // Bounce on ch0 ending high: exactly one rise pulse
    rise_cnt = 0;
    step(1'b1, 2'b01);
    step(1'b1, 2'b00); step(1'b1, 2'b01); step(1'b1, 2'b00);
    step(1'b1, 2'b01); step(1'b1, 2'b00); step(1'b1, 2'b01);
    hold(1'b1, 2'b01, 14);
    check("bounce_rise_count", 2'(rise_cnt), 2'd1);
    hold(1'b1, 2'b00, 16);

    // Short press on ch0
    hold(1'b1, 2'b01, 2);
    hold(1'b1, 2'b00, 16);

    // Release and re-press within the release lockout
    hold(1'b1, 2'b01, 16);
    step(1'b1, 2'b00);
    hold(1'b1, 2'b01, 16);

    // ch1 pressed while ch0 is in its release lockout
    step(1'b1, 2'b00);
    hold(1'b1, 2'b10, 16);
    hold(1'b1, 2'b00, 16);

    // Reset asserted mid-lockout
    hold(1'b1, 2'b11, 2);
    hold(1'b0, 2'b11, 2);
    hold(1'b1, 2'b11, 16);

    // Randomized slow-toggling inputs with occasional reset
    cur = 2'b11;
    for (int k = 0; k < 400; k++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 7) == 0) cur[ch] = ~cur[ch];
      rn = ($urandom_range(0, 199) != 0);
      step(rn, cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
